sipo_deserializer_rx: RTL and testbench
=======================================

Name: sipo_deserializer_rx

Overview:
Serial-in/parallel-out receiver: the receive end of the team's 4-bit parallel-in/serial-out shift link. It samples one bit per qualified clock, assembles WIDTH-bit words, and presents each completed word on a one-entry output register with a valid/ready handshake. Shifting of the next word continues while a completed word waits, and overrun is flagged.

Parameters:
WIDTH, 4, word length in bits; legal values 2..32.
MSB_FIRST, 0, 0 = first received bit lands in pout[0] (LSB-first); 1 = first received bit lands in pout[WIDTH-1].
CNT_W, $clog2(WIDTH+1), bit counter width; derived, do not override.

Ports:
clk  input  1  clock; all logic is on the rising edge.
rst  input  1  reset; synchronous, active-high.
sin  input  1  serial data bit.
sin_valid  input  1  sin is sampled only in cycles where this is high.
frame_start  input  1  when high together with sin_valid, sin is bit 0 of a new word and any partial word is discarded.
clr_overrun  input  1  clears the sticky overrun flag.
pout  output  WIDTH  assembled word; stable while pout_valid=1.
pout_valid  output  1  pout holds an unconsumed word.
pout_ready  input  1  consumer accepts pout when pout_valid & pout_ready.
busy  output  1  partial word in progress (bit_cnt != 0).
bit_cnt  output  CNT_W  bits collected in the current partial word, 0..WIDTH-1.
overrun  output  1  sticky: at least one completed word was dropped.

Behaviour:
- Reset (rst=1 at a clk edge): shift register=0, bit_cnt=0, pout=0, pout_valid=0, overrun=0, busy=0. Reset takes priority over all inputs, including mid-word and with pout_valid=1. The partial word and the held word are both discarded.
- States: IDLE (bit_cnt=0) and SHIFT (bit_cnt 1..WIDTH-1). The output buffer state (EMPTY/FULL = pout_valid) is tracked independently of these states.
- Sampling: each cycle with sin_valid=1, sin is written into bit position bit_cnt (LSB-first) or WIDTH-1-bit_cnt (MSB-first), and bit_cnt increments.
- Cycles with sin_valid=0 leave the shift register and bit_cnt unchanged, with no timeout. frame_start is ignored when sin_valid=0.
- frame_start=1 with sin_valid=1: the sampled bit is treated as bit 0 and bit_cnt becomes 1. A discarded partial word sets no flag.
- Word completion: the cycle in which the WIDTH-th bit is sampled. In that cycle bit_cnt returns to 0 and the full word, including that bit, is the completed word. If WIDTH=... any width, frame_start on the completing bit still counts as bit 0, so no completion occurs.
- Transfer on completion:
  - If pout_valid=0, or pout_valid=1 and pout_ready=1 in the same cycle: pout <= completed word and pout_valid=1 from the next cycle. Latency is 1 cycle from the sample edge of the last bit.
  - If pout_valid=1 and pout_ready=0: the completed word is dropped, pout is unchanged and overrun <= 1.
- Handshake: pout_valid & pout_ready with no simultaneous completion gives pout_valid <= 0 next cycle. pout keeps its last value, and its content is don't-care when pout_valid=0. pout_ready is ignored while pout_valid=0.
- Throughput: back-to-back words with sin_valid held high and pout_ready held high give one word every WIDTH cycles, with no bubbles.
- overrun: set as above and cleared by clr_overrun. If set and clear occur in the same cycle, set wins.
- busy = (bit_cnt != 0), combinational from the registered bit_cnt.

Decomposition:
- Package sipo_pkg holds two items:
  - localparam defaults (WIDTH_DEF=4).
  - A typedef enum {RX_IDLE, RX_SHIFT} rx_state_t, used for debug visibility.
- Sub-module sipo_shift_core contains the shift register, the bit counter, the frame_start alignment, and the MSB_FIRST mapping. It outputs a completed word and a word_done pulse.
- The top level contains the output buffer, the handshake logic, and the overrun logic.

Test Plan:
- Basic word: WIDTH=4, LSB-first, sin_valid=1 with sin=1,0,1,1 and pout_ready=0. pout_valid rises the cycle after the 4th bit with pout=4'hD, and busy is high for bits 1-3.
- MSB-first: the same bits with MSB_FIRST=1 give pout=4'hB.
- Gaps and realign: bits 1,1 are sent, then sin_valid=0 for 3 cycles, then frame_start+sin=0, then 1,1,1. This gives pout=4'hE, and the first two bits are discarded.
- Overrun: word 4'h5 is completed and held with pout_ready=0, then word 4'hA is completed. pout stays 4'h5 and overrun=1. clr_overrun=1 for one cycle gives overrun=0.
- Same-cycle accept and complete: pout_valid=1 with 4'h3, and pout_ready=1 in the last-bit cycle of 4'hC. The next cycle shows pout=4'hC, pout_valid=1, and overrun=0.
- Reset mid-word: after 2 bits plus a held word, rst=1 for one cycle gives pout_valid=0, bit_cnt=0, overrun=0. Then 4 bits 0,1,0,0 give pout=4'h2.

Source files
------------

// File: rtl/sipo_pkg.sv
// Shared definitions for the serial-in/parallel-out receiver.
//   WIDTH_DEF  : default word length in bits
//   rx_state_t : shift-core state, kept for debug visibility
package sipo_pkg;

    localparam int unsigned WIDTH_DEF = 4;

    typedef enum logic [0:0] {
        RX_IDLE  = 1'b0,
        RX_SHIFT = 1'b1
    } rx_state_t;

endpackage

// File: rtl/sipo_deserializer_rx_shift_core.sv
// Shift core: collects one bit per qualified cycle into a WIDTH-bit word.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   sin_i, sin_valid_i  : serial bit and its qualifier
//   frame_start_i       : with sin_valid_i, marks sin_i as bit 0 of a new word
//   word_o, word_done_o : completed word, valid in the cycle word_done_o pulses
//   bit_cnt_o           : bits collected in the current partial word
module sipo_shift_core
    import sipo_pkg::*;
#(
    parameter int unsigned WIDTH     = WIDTH_DEF,
    parameter bit          MSB_FIRST = 1'b0,
    parameter int unsigned CNT_W     = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sin_i,
    input  logic             sin_valid_i,
    input  logic             frame_start_i,
    output logic [WIDTH-1:0] word_o,
    output logic             word_done_o,
    output logic [CNT_W-1:0] bit_cnt_o
);

    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    rx_state_t        state_q, state_d;

    logic [CNT_W-1:0] idx;
    logic [WIDTH-1:0] word_v;
    int               pos;

    always_comb begin
        shreg_d     = shreg_q;
        cnt_d       = cnt_q;
        word_v      = shreg_q;
        word_done_o = 1'b0;
        idx         = cnt_q;
        pos         = 0;

        if (sin_valid_i) begin
            // A frame start realigns: the partial word is dropped silently.
            if (frame_start_i || (state_q == RX_IDLE)) begin
                idx    = '0;
                word_v = '0;
            end
            pos = MSB_FIRST ? (int'(WIDTH) - 1 - int'(idx)) : int'(idx);
            for (int i = 0; i < int'(WIDTH); i++) begin
                if (i == pos) begin
                    word_v[i] = sin_i;
                end
            end
            if (idx == CNT_W'(WIDTH - 1)) begin
                word_done_o = 1'b1;
                cnt_d       = '0;
                shreg_d     = '0;
            end else begin
                cnt_d   = idx + CNT_W'(1);
                shreg_d = word_v;
            end
        end

        state_d = (cnt_d == '0) ? RX_IDLE : RX_SHIFT;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shreg_q <= '0;
            cnt_q   <= '0;
            state_q <= RX_IDLE;
        end else begin
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            state_q <= state_d;
        end
    end

    assign word_o    = word_v;
    assign bit_cnt_o = cnt_q;

endmodule

// File: rtl/sipo_deserializer_rx.sv
// Serial-in/parallel-out receiver with a one-entry valid/ready output register.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   sin_i, sin_valid_i       : serial bit and its qualifier
//   frame_start_i            : realign, sin_i becomes bit 0 of a new word
//   clr_overrun_i            : clears the sticky overrun flag
//   pout_o, pout_valid_o     : held word and its valid flag
//   pout_ready_i             : consumer accepts pout_o when valid & ready
//   busy_o, bit_cnt_o        : partial-word status
//   overrun_o                : sticky, a completed word was dropped
module sipo_deserializer_rx
    import sipo_pkg::*;
#(
    parameter int unsigned WIDTH     = WIDTH_DEF,
    parameter bit          MSB_FIRST = 1'b0,
    parameter int unsigned CNT_W     = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sin_i,
    input  logic             sin_valid_i,
    input  logic             frame_start_i,
    input  logic             clr_overrun_i,
    output logic [WIDTH-1:0] pout_o,
    output logic             pout_valid_o,
    input  logic             pout_ready_i,
    output logic             busy_o,
    output logic [CNT_W-1:0] bit_cnt_o,
    output logic             overrun_o
);

    logic [WIDTH-1:0] word;
    logic             word_done;

    logic [WIDTH-1:0] pout_q, pout_d;
    logic             valid_q, valid_d;
    logic             overrun_q, overrun_d;
    logic             overrun_set;

    sipo_shift_core #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST),
        .CNT_W     (CNT_W)
    ) u_core (
        .clk           (clk),
        .rst           (rst),
        .sin_i         (sin_i),
        .sin_valid_i   (sin_valid_i),
        .frame_start_i (frame_start_i),
        .word_o        (word),
        .word_done_o   (word_done),
        .bit_cnt_o     (bit_cnt_o)
    );

    always_comb begin
        pout_d      = pout_q;
        valid_d     = valid_q;
        overrun_set = 1'b0;

        if (word_done) begin
            // A word accepted this cycle frees the slot for the new one.
            if (!valid_q || pout_ready_i) begin
                pout_d  = word;
                valid_d = 1'b1;
            end else begin
                overrun_set = 1'b1;
            end
        end else if (valid_q && pout_ready_i) begin
            valid_d = 1'b0;
        end

        // Set beats clear.
        if (overrun_set) begin
            overrun_d = 1'b1;
        end else if (clr_overrun_i) begin
            overrun_d = 1'b0;
        end else begin
            overrun_d = overrun_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pout_q    <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            pout_q    <= pout_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    assign pout_o       = pout_q;
    assign pout_valid_o = valid_q;
    assign overrun_o    = overrun_q;
    assign busy_o       = (bit_cnt_o != '0);

endmodule

// File: tb/tb_sipo_deserializer_rx.sv
// Directed bench for sipo_deserializer_rx: an LSB-first and an MSB-first
// instance share one stimulus stream.
module tb_sipo_deserializer_rx;

    localparam int unsigned W  = 4;
    localparam int unsigned CW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          sin, sin_valid, frame_start, clr_overrun, pout_ready;
    logic [W-1:0]  pout, pout_m;
    logic          pout_valid, pout_valid_m;
    logic          busy, busy_m;
    logic [CW-1:0] bit_cnt, bit_cnt_m;
    logic          overrun, overrun_m;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    sipo_deserializer_rx #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
        .clk           (clk),
        .rst           (rst),
        .sin_i         (sin),
        .sin_valid_i   (sin_valid),
        .frame_start_i (frame_start),
        .clr_overrun_i (clr_overrun),
        .pout_o        (pout),
        .pout_valid_o  (pout_valid),
        .pout_ready_i  (pout_ready),
        .busy_o        (busy),
        .bit_cnt_o     (bit_cnt),
        .overrun_o     (overrun)
    );

    sipo_deserializer_rx #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_msb (
        .clk           (clk),
        .rst           (rst),
        .sin_i         (sin),
        .sin_valid_i   (sin_valid),
        .frame_start_i (frame_start),
        .clr_overrun_i (clr_overrun),
        .pout_o        (pout_m),
        .pout_valid_o  (pout_valid_m),
        .pout_ready_i  (pout_ready),
        .busy_o        (busy_m),
        .bit_cnt_o     (bit_cnt_m),
        .overrun_o     (overrun_m)
    );

    // Inputs change on the falling edge; outputs are read right after that
    // falling edge, i.e. they show the result of the previous rising edge.
    task automatic drive(input logic v, input logic b, input logic fs,
                         input logic rdy, input logic clr);
        @(negedge clk);
        sin_valid   = v;
        sin         = b;
        frame_start = fs;
        pout_ready  = rdy;
        clr_overrun = clr;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Send a 4-bit word in transmit order b[0] first; ready held as given.
    task automatic send_word(input logic [W-1:0] b, input logic rdy);
        for (int i = 0; i < int'(W); i++) begin
            drive(1'b1, b[i], 1'b0, rdy, 1'b0);
        end
    endtask

    task automatic consume();
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        idle();
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1; sin = 0; sin_valid = 0; frame_start = 0; clr_overrun = 0; pout_ready = 0;
        @(negedge clk);
        rst = 1'b0;
        tests++;
        if (pout_valid !== 1'b0 || pout !== 4'h0) begin
            $display("FAIL reset_pout: valid=%b pout=%h want 0/0", pout_valid, pout); fails++;
        end
        tests++;
        if (bit_cnt !== 3'd0 || busy !== 1'b0 || overrun !== 1'b0) begin
            $display("FAIL reset_cnt: cnt=%0d busy=%b ovr=%b want 0/0/0", bit_cnt, busy, overrun);
            fails++;
        end
    endtask

    task automatic test_basic();
        logic [2:0] cnt_exp;
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i < 4; i++) begin
            drive(1'b1, (i == 1) ? 1'b0 : 1'b1, 1'b0, 1'b0, 1'b0);
            cnt_exp = 3'(i);
            tests++;
            if (bit_cnt !== cnt_exp || busy !== 1'b1 || pout_valid !== 1'b0) begin
                $display("FAIL basic_shift%0d: cnt=%0d busy=%b valid=%b want %0d/1/0",
                         i, bit_cnt, busy, pout_valid, cnt_exp);
                fails++;
            end
        end
        idle();
        tests++;
        if (pout_valid !== 1'b1 || pout !== 4'hD || busy !== 1'b0 || bit_cnt !== 3'd0) begin
            $display("FAIL basic_word: valid=%b pout=%h busy=%b cnt=%0d want 1/d/0/0",
                     pout_valid, pout, busy, bit_cnt);
            fails++;
        end
        tests++;
        if (pout_valid_m !== 1'b1 || pout_m !== 4'hB) begin
            $display("FAIL msb_word: valid=%b pout=%h want 1/b", pout_valid_m, pout_m); fails++;
        end
        consume();
        tests++;
        if (pout_valid !== 1'b0 || pout_valid_m !== 1'b0) begin
            $display("FAIL basic_consume: valid=%b/%b want 0/0", pout_valid, pout_valid_m);
            fails++;
        end
    endtask

    task automatic test_gaps();
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(); idle(); idle();
        tests++;
        if (bit_cnt !== 3'd2 || busy !== 1'b1) begin
            $display("FAIL gap_hold: cnt=%0d busy=%b want 2/1", bit_cnt, busy); fails++;
        end
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        tests++;
        if (bit_cnt !== 3'd1) begin
            $display("FAIL realign_cnt: cnt=%0d want 1", bit_cnt); fails++;
        end
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        idle();
        tests++;
        if (pout_valid !== 1'b1 || pout !== 4'hE || overrun !== 1'b0) begin
            $display("FAIL realign_word: valid=%b pout=%h ovr=%b want 1/e/0",
                     pout_valid, pout, overrun);
            fails++;
        end
        tests++;
        if (pout_m !== 4'h7) begin
            $display("FAIL realign_msb: pout=%h want 7", pout_m); fails++;
        end
        consume();
    endtask

    task automatic test_overrun();
        send_word(4'h5, 1'b0);
        idle();
        tests++;
        if (pout !== 4'h5 || pout_valid !== 1'b1 || overrun !== 1'b0) begin
            $display("FAIL ovr_first: pout=%h valid=%b ovr=%b want 5/1/0", pout, pout_valid, overrun);
            fails++;
        end
        send_word(4'hA, 1'b0);
        idle();
        tests++;
        if (pout !== 4'h5 || pout_valid !== 1'b1 || overrun !== 1'b1) begin
            $display("FAIL ovr_drop: pout=%h valid=%b ovr=%b want 5/1/1", pout, pout_valid, overrun);
            fails++;
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        idle();
        tests++;
        if (overrun !== 1'b0 || pout_valid !== 1'b1) begin
            $display("FAIL ovr_clear: ovr=%b valid=%b want 0/1", overrun, pout_valid); fails++;
        end
        // Second drop with clear in the completing cycle: set must win.
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        idle();
        tests++;
        if (overrun !== 1'b1 || pout !== 4'h5) begin
            $display("FAIL ovr_set_wins: ovr=%b pout=%h want 1/5", overrun, pout); fails++;
        end
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        idle();
        tests++;
        if (overrun !== 1'b0 || pout_valid !== 1'b0) begin
            $display("FAIL ovr_release: ovr=%b valid=%b want 0/0", overrun, pout_valid); fails++;
        end
    endtask

    task automatic test_same_cycle();
        send_word(4'h3, 1'b0);
        idle();
        tests++;
        if (pout !== 4'h3 || pout_valid !== 1'b1) begin
            $display("FAIL sc_first: pout=%h valid=%b want 3/1", pout, pout_valid); fails++;
        end
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        idle();
        tests++;
        if (pout !== 4'hC || pout_valid !== 1'b1 || overrun !== 1'b0) begin
            $display("FAIL sc_accept: pout=%h valid=%b ovr=%b want c/1/0", pout, pout_valid, overrun);
            fails++;
        end
        consume();
    endtask

    task automatic test_reset_mid();
        send_word(4'h9, 1'b0);
        send_word(4'h6, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        idle();
        tests++;
        if (pout !== 4'h9 || overrun !== 1'b1 || bit_cnt !== 3'd2) begin
            $display("FAIL rm_pre: pout=%h ovr=%b cnt=%0d want 9/1/2", pout, overrun, bit_cnt);
            fails++;
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        tests++;
        if (pout_valid !== 1'b0 || bit_cnt !== 3'd0 || overrun !== 1'b0 || busy !== 1'b0) begin
            $display("FAIL rm_reset: valid=%b cnt=%0d ovr=%b busy=%b want 0/0/0/0",
                     pout_valid, bit_cnt, overrun, busy);
            fails++;
        end
        send_word(4'h2, 1'b0);
        idle();
        tests++;
        if (pout !== 4'h2 || pout_valid !== 1'b1) begin
            $display("FAIL rm_after: pout=%h valid=%b want 2/1", pout, pout_valid); fails++;
        end
        consume();
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] words [3];
        words[0] = 4'hF; words[1] = 4'h1; words[2] = 4'h6;
        for (int w = 0; w < 3; w++) begin
            for (int i = 0; i < int'(W); i++) begin
                drive(1'b1, words[w][i], 1'b0, 1'b1, 1'b0);
                if (i == 0 && w > 0) begin
                    tests++;
                    if (pout_valid !== 1'b1 || pout !== words[w-1]) begin
                        $display("FAIL b2b_word%0d: valid=%b pout=%h want 1/%h",
                                 w - 1, pout_valid, pout, words[w-1]);
                        fails++;
                    end
                end
            end
        end
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        tests++;
        if (pout_valid !== 1'b1 || pout !== 4'h6 || overrun !== 1'b0) begin
            $display("FAIL b2b_last: valid=%b pout=%h ovr=%b want 1/6/0", pout_valid, pout, overrun);
            fails++;
        end
        idle();
        tests++;
        if (pout_valid !== 1'b0) begin
            $display("FAIL b2b_drain: valid=%b want 0", pout_valid); fails++;
        end
    endtask

    initial begin
        rst = 1'b1; sin = 0; sin_valid = 0; frame_start = 0; clr_overrun = 0; pout_ready = 0;
        test_reset();
        test_basic();
        test_gaps();
        test_overrun();
        test_same_cycle();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
